matrix_axi_bridge: RTL

MATRIX_AXI_BRIDGE -- requirements
Module: matrix_axi_bridge

---
 rtl/matrix_axi_bridge_pkg.sv | 18 +
 rtl/ising_addr_decode.sv | 30 +++
 rtl/matrix_axi_bridge.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/matrix_axi_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to matrix weight-port bridge.
// Holds the FSM encoding and the response/read-miss codes used by the bridge.
package matrix_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_EXEC  = 3'd1,
    WR_RESP  = 3'd2,
    RD_SETUP = 3'd3,
    RD_CAPT  = 3'd4,
    RD_RESP  = 3'd5
  } state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_SLVERR  = 2'b10;
  localparam logic [31:0] RD_MISS_DATA = 32'hAAAA_AAAA;

endpackage

// File: rtl/ising_addr_decode.sv
// Combinational split of a bridge byte address into matrix cell fields.
// Layout, LSB first: 2 ignored bits, d (L bits), s (L bits), vh, then guard bits.
module ising_addr_decode #(
  parameter int ADDR_W = 32,
  parameter int L      = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [L-1:0]      s,
  output logic [L-1:0]      d,
  output logic              vh,
  output logic              guard_err
);

  // Byte-lane bits carry no meaning for 32-bit word accesses.
  logic unused_byte_lane;
  assign unused_byte_lane = ^addr[1:0];

  assign d  = addr[2+L-1:2];
  assign s  = addr[2+2*L-1:2+L];
  assign vh = addr[2+2*L];

  generate
    if (ADDR_W > 2*L+3) begin : g_guard
      assign guard_err = |addr[ADDR_W-1:2*L+3];
    end else begin : g_no_guard
      assign guard_err = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/matrix_axi_bridge.sv
// AXI4-Lite slave that turns single-beat accesses into matrix weight-port cycles.
// One transaction in flight; a complete write beats a concurrent read in IDLE.
module matrix_axi_bridge
  import matrix_axi_bridge_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int ADDR_W = 32,
  localparam int L      = $clog2(N)
) (
  input  logic              clk,
  input  logic              axi_rstn,

  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,

  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,

  output logic              m_wready,
  output logic              m_wr_match,
  output logic [L:0]        m_s_addr,
  output logic [L:0]        m_d_addr,
  output logic              m_vh,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,

  output logic              busy
);

  state_t state_q, state_d;

  logic [L-1:0] aw_s, aw_d, ar_s, ar_d;
  logic         aw_vh, ar_vh, aw_guard, ar_guard;

  logic [L-1:0] s_q, d_q;
  logic         vh_q, guard_q;
  logic [31:0]  wdata_q, rdata_q;
  logic [1:0]   bresp_q, rresp_q;

  logic wr_hs, rd_hs;

  ising_addr_decode #(.ADDR_W(ADDR_W), .L(L)) u_aw_decode (
    .addr      (s_axi_awaddr),
    .s         (aw_s),
    .d         (aw_d),
    .vh        (aw_vh),
    .guard_err (aw_guard)
  );

  ising_addr_decode #(.ADDR_W(ADDR_W), .L(L)) u_ar_decode (
    .addr      (s_axi_araddr),
    .s         (ar_s),
    .d         (ar_d),
    .vh        (ar_vh),
    .guard_err (ar_guard)
  );

  // AW and W are only ever taken as a pair; the reset gate keeps every
  // ready low while axi_rstn is asserted even if a master holds valid high.
  assign wr_hs = axi_rstn && (state_q == IDLE) && s_axi_awvalid && s_axi_wvalid;
  assign rd_hs = axi_rstn && (state_q == IDLE) && s_axi_arvalid
                 && !(s_axi_awvalid && s_axi_wvalid);

  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_arready = rd_hs;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_hs)      state_d = WR_EXEC;
        else if (rd_hs) state_d = RD_SETUP;
      end
      WR_EXEC:  state_d = WR_RESP;
      WR_RESP:  if (s_axi_bready) state_d = IDLE;
      RD_SETUP: state_d = RD_CAPT;
      RD_CAPT:  state_d = RD_RESP;
      RD_RESP:  if (s_axi_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers are few and drive outputs directly, so they are reset
  // to give all-zero outputs during reset.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      s_q     <= '0;
      d_q     <= '0;
      vh_q    <= 1'b0;
      guard_q <= 1'b0;
      wdata_q <= '0;
      bresp_q <= RESP_OKAY;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (wr_hs) begin
        s_q     <= aw_s;
        d_q     <= aw_d;
        vh_q    <= aw_vh;
        guard_q <= aw_guard;
        wdata_q <= s_axi_wdata;
      end else if (rd_hs) begin
        s_q     <= ar_s;
        d_q     <= ar_d;
        vh_q    <= ar_vh;
        guard_q <= ar_guard;
      end
      if (state_q == WR_EXEC) begin
        bresp_q <= guard_q ? RESP_SLVERR : RESP_OKAY;
      end
      if (state_q == RD_CAPT) begin
        rdata_q <= guard_q ? RD_MISS_DATA : m_rdata;
        rresp_q <= guard_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Cell select spans the whole access window; the strobe only the write cycle.
  assign m_wr_match = !guard_q && ((state_q == WR_EXEC) || (state_q == RD_SETUP)
                                   || (state_q == RD_CAPT));
  assign m_wready   = !guard_q && (state_q == WR_EXEC);
  assign m_s_addr   = {1'b0, s_q};
  assign m_d_addr   = {1'b0, d_q};
  assign m_vh       = vh_q;
  assign m_wdata    = wdata_q;

  assign s_axi_bvalid = (state_q == WR_RESP);
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = (state_q == RD_RESP);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

  assign busy = (state_q != IDLE);

endmodule
